// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_hazard_reg
//  Description : ID/EX pipeline register for the 5-stage MIPS core. Captures
//                the decoder controls and operands for EX. When a load in EX
//                feeds an operand of the instruction in ID, it inserts one
//                bubble and stalls PC and IF/ID. A branch flush from MEM kills
//                the ID instruction. A saturating counter records the number
//                of hazard stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic              Branch_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [5:0]        funct_i,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              Branch_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_addr_o,
    output logic [4:0]        rt_addr_o,
    output logic [4:0]        wr_addr_o,
    output logic [5:0]        funct_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // EX-stage state
    logic [1:0]        r_alu_op;
    logic              r_alu_src;
    logic              r_branch;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rs_addr;
    logic [4:0]        r_rt_addr;
    logic [4:0]        r_wr_addr;
    logic [5:0]        r_funct;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_rt_is_src;
    logic w_haz;
    logic w_bubble;

    // rt is a source operand only for R-type, beq and sw; addi/slti/lw write it.
    assign w_rt_is_src = ~ALUSrc_i | MemWrite_i;

    // Load in EX whose destination is read by the real instruction in ID.
    assign w_haz = r_valid & r_mem_read & valid_i & (r_rt_addr != 5'd0) &
                   ((r_rt_addr == rs_addr_i) | ((r_rt_addr == rt_addr_i) & w_rt_is_src));

    // A flushed instruction is about to die, so it must never hold the PC.
    assign stall_o  = w_haz & ~flush_i & ~rst_i;
    assign w_bubble = flush_i | w_haz | ~valid_i;

    // Pipeline register: a bubble zeroes the controls and holds the data fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_alu_op     <= 2'b00;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_pc_plus4   <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs_addr    <= 5'd0;
            r_rt_addr    <= 5'd0;
            r_wr_addr    <= 5'd0;
            r_funct      <= 6'd0;
            r_valid      <= 1'b0;
        end else if (w_bubble) begin
            r_alu_op     <= 2'b00;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_alu_op     <= ALUOp_i;
            r_alu_src    <= ALUSrc_i;
            r_branch     <= Branch_i;
            r_mem_read   <= MemRead_i;
            r_mem_write  <= MemWrite_i;
            r_reg_write  <= RegWrite_i;
            r_mem_to_reg <= MemToReg_i;
            r_pc_plus4   <= pc_plus4_i;
            r_rs_data    <= rs_data_i;
            r_rt_data    <= rt_data_i;
            r_imm        <= imm_i;
            r_rs_addr    <= rs_addr_i;
            r_rt_addr    <= rt_addr_i;
            r_wr_addr    <= RegDst_i ? rd_addr_i : rt_addr_i;
            r_funct      <= funct_i;
            r_valid      <= 1'b1;
        end
    end

    // Saturating count of hazard stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_o && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ALUOp_o     = r_alu_op;
    assign ALUSrc_o    = r_alu_src;
    assign Branch_o    = r_branch;
    assign MemRead_o   = r_mem_read;
    assign MemWrite_o  = r_mem_write;
    assign RegWrite_o  = r_reg_write;
    assign MemToReg_o  = r_mem_to_reg;
    assign pc_plus4_o  = r_pc_plus4;
    assign rs_data_o   = r_rs_data;
    assign rt_data_o   = r_rt_data;
    assign imm_o       = r_imm;
    assign rs_addr_o   = r_rs_addr;
    assign rt_addr_o   = r_rt_addr;
    assign wr_addr_o   = r_wr_addr;
    assign funct_o     = r_funct;
    assign valid_o     = r_valid;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_hazard_reg
//  Description : Directed scoreboard bench for id_ex_hazard_reg. A second
//                instance with a 2-bit counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 32;
    localparam int K_ADD = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_X = 4;

    // Control byte layout: {ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemToReg}
    localparam logic [7:0] C_ADD  = 8'b1000_0010;
    localparam logic [7:0] C_LW   = 8'b0010_1011;
    localparam logic [7:0] C_SW   = 8'b0010_0100;
    localparam logic [7:0] C_ADDI = 8'b0010_0010;
    localparam logic [7:0] C_BUB  = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst_i, valid_i, flush_i;
    logic [1:0] ALUOp_i;
    logic ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i;
    logic [DATA_W-1:0] pc_plus4_i, rs_data_i, rt_data_i, imm_i;
    logic [4:0] rs_addr_i, rt_addr_i, rd_addr_i;
    logic [5:0] funct_i;

    logic [1:0] ALUOp_o;
    logic ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o;
    logic [DATA_W-1:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0] rs_addr_o, rt_addr_o, wr_addr_o;
    logic [5:0] funct_o;
    logic valid_o, stall_o;
    logic [15:0] stall_cnt_o;

    logic [1:0] d2_ALUOp;
    logic d2_ALUSrc, d2_Branch, d2_MemRead, d2_MemWrite, d2_RegWrite, d2_MemToReg;
    logic [DATA_W-1:0] d2_pc, d2_rsd, d2_rtd, d2_imm;
    logic [4:0] d2_rs, d2_rt, d2_wr;
    logic [5:0] d2_funct;
    logic d2_valid, d2_stall;
    logic [1:0] d2_cnt;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
        .MemToReg_i(MemToReg_i), .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i),
        .rt_data_i(rt_data_i), .imm_i(imm_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rd_addr_i(rd_addr_i), .funct_i(funct_i),
        .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
        .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .wr_addr_o(wr_addr_o), .funct_o(funct_o),
        .valid_o(valid_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    id_ex_hazard_reg #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .Branch_i(Branch_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
        .MemToReg_i(MemToReg_i), .pc_plus4_i(pc_plus4_i), .rs_data_i(rs_data_i),
        .rt_data_i(rt_data_i), .imm_i(imm_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rd_addr_i(rd_addr_i), .funct_i(funct_i),
        .ALUOp_o(d2_ALUOp), .ALUSrc_o(d2_ALUSrc), .Branch_o(d2_Branch), .MemRead_o(d2_MemRead),
        .MemWrite_o(d2_MemWrite), .RegWrite_o(d2_RegWrite), .MemToReg_o(d2_MemToReg),
        .pc_plus4_o(d2_pc), .rs_data_o(d2_rsd), .rt_data_o(d2_rtd), .imm_o(d2_imm),
        .rs_addr_o(d2_rs), .rt_addr_o(d2_rt), .wr_addr_o(d2_wr), .funct_o(d2_funct),
        .valid_o(d2_valid), .stall_o(d2_stall), .stall_cnt_o(d2_cnt)
    );

    typedef struct {
        string             name;
        logic [7:0]        ctrl;
        logic              vld;
        logic              chk_data;
        logic [4:0]        wr;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rsd;
        logic [DATA_W-1:0] rtd;
        logic [DATA_W-1:0] imm;
        logic [5:0]        funct;
        logic              stall;
        logic [15:0]       cnt;
        logic [1:0]        cnt2;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_vec  = 0;

    // Fields most recently loaded into EX, known from the stimulus alone.
    logic [4:0]        ld_rt;
    logic [DATA_W-1:0] ld_pc, ld_rsd, ld_rtd, ld_imm;
    logic [5:0]        ld_funct;

    task automatic chk(input string vec, input string fld, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", vec, fld, act, exp);
        end
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.name, "valid_o", 64'(valid_o), 64'(e.vld));
                chk(e.name, "ctrl", 64'({ALUOp_o, ALUSrc_o, Branch_o, MemRead_o,
                                         MemWrite_o, RegWrite_o, MemToReg_o}), 64'(e.ctrl));
                chk(e.name, "stall_o", 64'(stall_o), 64'(e.stall));
                chk(e.name, "stall_cnt_o", 64'(stall_cnt_o), 64'(e.cnt));
                chk(e.name, "sat_cnt", 64'(d2_cnt), 64'(e.cnt2));
                if (e.chk_data) begin
                    chk(e.name, "wr_addr_o", 64'(wr_addr_o), 64'(e.wr));
                    chk(e.name, "rs_addr_o", 64'(rs_addr_o), 64'(e.rs));
                    chk(e.name, "rt_addr_o", 64'(rt_addr_o), 64'(e.rt));
                    chk(e.name, "pc_plus4_o", 64'(pc_plus4_o), 64'(e.pc));
                    chk(e.name, "rs_data_o", 64'(rs_data_o), 64'(e.rsd));
                    chk(e.name, "rt_data_o", 64'(rt_data_o), 64'(e.rtd));
                    chk(e.name, "imm_o", 64'(imm_o), 64'(e.imm));
                    chk(e.name, "funct_o", 64'(funct_o), 64'(e.funct));
                end
            end
        end
    end

    // Drive one cycle of ID inputs and push the hand-computed expectation for
    // the falling edge of that same cycle (EX regs from the previous edge,
    // stall_o for these inputs, counters after the previous edge).
    task automatic step(input string nm, input int kind, input bit v, input bit fl, input bit r,
                        input int rs, input int rt, input int rd,
                        input logic [7:0] e_ctrl, input bit e_vld, input bit e_chk, input bit e_zero,
                        input int e_wr, input int e_rs, input bit e_stall,
                        input int e_cnt, input int e_cnt2);
        exp_t e;
        @(posedge clk);
        #2;
        n_vec++;
        rst_i = r; valid_i = v; flush_i = fl;
        rs_addr_i = 5'(rs); rt_addr_i = 5'(rt); rd_addr_i = 5'(rd);
        if (r) begin
            pc_plus4_i = $urandom; rs_data_i = $urandom; rt_data_i = $urandom;
            imm_i = $urandom; funct_i = 6'($urandom);
        end else begin
            pc_plus4_i = 32'h0000_0400 + 32'(n_vec * 4);
            rs_data_i  = 32'h0101_0101 * 32'(n_vec);
            rt_data_i  = ~(32'h0101_0101 * 32'(n_vec));
            imm_i      = 32'(n_vec) - 32'd8;
            funct_i    = 6'(n_vec + 32);
        end
        RegDst_i = 1'b0; Branch_i = 1'b0;
        case (kind)
            K_ADD:  begin {ALUOp_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i} = 7'b10_0_0_0_1_0; RegDst_i = 1'b1; end
            K_LW:   {ALUOp_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i} = 7'b00_1_1_0_1_1;
            K_SW:   {ALUOp_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i} = 7'b00_1_0_1_0_0;
            K_ADDI: {ALUOp_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i} = 7'b00_1_0_0_1_0;
            default: begin
                {ALUOp_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i} = 'x;
                RegDst_i = 1'bx; Branch_i = 1'bx;
            end
        endcase
        e.name = nm; e.ctrl = e_ctrl; e.vld = e_vld; e.chk_data = e_chk | e_zero;
        e.stall = e_stall; e.cnt = 16'(e_cnt); e.cnt2 = 2'(e_cnt2);
        if (e_zero) begin
            e.wr = '0; e.rs = '0; e.rt = '0; e.pc = '0; e.rsd = '0; e.rtd = '0; e.imm = '0; e.funct = '0;
        end else begin
            e.wr = 5'(e_wr); e.rs = 5'(e_rs); e.rt = ld_rt; e.pc = ld_pc; e.rsd = ld_rsd;
            e.rtd = ld_rtd; e.imm = ld_imm; e.funct = ld_funct;
        end
        q.push_back(e);
        if (!r && !fl && v && !e_stall) begin
            ld_rt = 5'(rt); ld_pc = pc_plus4_i; ld_rsd = rs_data_i; ld_rtd = rt_data_i;
            ld_imm = imm_i; ld_funct = funct_i;
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        {ALUOp_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i} = '0;
        pc_plus4_i = '0; rs_data_i = '0; rt_data_i = '0; imm_i = '0;
        rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0; funct_i = '0;
        ld_rt = '0; ld_pc = '0; ld_rsd = '0; ld_rtd = '0; ld_imm = '0; ld_funct = '0;
        @(posedge clk);
        //    name         kind    v  fl r  rs rt rd  e_ctrl  vld chk zero wr rs stall cnt c2
        step("rst_hold",   K_LW,   1, 0, 1, 5, 5, 7,  C_BUB,  0,  0,  1,   0, 0, 0,    0,  0);
        step("rst_done",   K_ADD,  1, 0, 0, 1, 2, 3,  C_BUB,  0,  0,  1,   0, 0, 0,    0,  0);
        step("add_in_ex",  K_LW,   1, 0, 0, 1, 5, 0,  C_ADD,  1,  1,  0,   3, 1, 0,    0,  0);
        step("lu_stall",   K_ADD,  1, 0, 0, 5, 2, 6,  C_LW,   1,  1,  0,   5, 1, 1,    0,  0);
        step("lu_bubble",  K_ADD,  1, 0, 0, 5, 2, 6,  C_BUB,  0,  0,  0,   0, 0, 0,    1,  1);
        step("lu_add_ex",  K_LW,   1, 0, 0, 1, 0, 0,  C_ADD,  1,  1,  0,   6, 5, 0,    1,  1);
        step("lw_r0",      K_ADD,  1, 0, 0, 0, 2, 6,  C_LW,   1,  1,  0,   0, 1, 0,    1,  1);
        step("r0_add_ex",  K_LW,   1, 0, 0, 1, 5, 0,  C_ADD,  1,  1,  0,   6, 0, 0,    1,  1);
        step("addi_dst",   K_ADDI, 1, 0, 0, 1, 5, 0,  C_LW,   1,  1,  0,   5, 1, 0,    1,  1);
        step("addi_ex",    K_LW,   1, 0, 0, 1, 5, 0,  C_ADDI, 1,  1,  0,   5, 1, 0,    1,  1);
        step("sw_src",     K_SW,   1, 0, 0, 2, 5, 0,  C_LW,   1,  1,  0,   5, 1, 1,    1,  1);
        step("sw_bubble",  K_SW,   1, 0, 0, 2, 5, 0,  C_BUB,  0,  0,  0,   0, 0, 0,    2,  2);
        step("sw_ex",      K_LW,   1, 0, 0, 1, 5, 0,  C_SW,   1,  1,  0,   5, 2, 0,    2,  2);
        step("flush_haz",  K_ADD,  1, 1, 0, 5, 2, 6,  C_LW,   1,  1,  0,   5, 1, 0,    2,  2);
        step("inv_x",      K_X,    0, 0, 0, 5, 2, 6,  C_BUB,  0,  0,  0,   0, 0, 0,    2,  2);
        step("x_bubble",   K_ADD,  1, 0, 0, 1, 2, 3,  C_BUB,  0,  0,  0,   0, 0, 0,    2,  2);
        step("sat_lw1",    K_LW,   1, 0, 0, 1, 5, 0,  C_ADD,  1,  1,  0,   3, 1, 0,    2,  2);
        step("sat_st1",    K_ADD,  1, 0, 0, 5, 2, 6,  C_LW,   1,  1,  0,   5, 1, 1,    2,  2);
        step("sat_bub1",   K_ADD,  1, 0, 0, 5, 2, 6,  C_BUB,  0,  0,  0,   0, 0, 0,    3,  3);
        step("sat_lw2",    K_LW,   1, 0, 0, 1, 5, 0,  C_ADD,  1,  1,  0,   6, 5, 0,    3,  3);
        step("sat_st2",    K_ADD,  1, 0, 0, 5, 2, 6,  C_LW,   1,  1,  0,   5, 1, 1,    3,  3);
        step("sat_bub2",   K_ADD,  1, 0, 0, 5, 2, 6,  C_BUB,  0,  0,  0,   0, 0, 0,    4,  3);
        step("sat_lw3",    K_LW,   1, 0, 0, 1, 5, 0,  C_ADD,  1,  1,  0,   6, 5, 0,    4,  3);
        step("sat_st3",    K_ADD,  1, 0, 0, 5, 2, 6,  C_LW,   1,  1,  0,   5, 1, 1,    4,  3);
        step("sat_bub3",   K_ADD,  1, 0, 0, 5, 2, 6,  C_BUB,  0,  0,  0,   0, 0, 0,    5,  3);
        step("mid_lw",     K_LW,   1, 0, 0, 1, 5, 0,  C_ADD,  1,  1,  0,   6, 5, 0,    5,  3);
        step("mid_rst",    K_ADD,  1, 0, 1, 5, 2, 6,  C_LW,   1,  1,  0,   5, 1, 0,    5,  3);
        step("post_rst",   K_ADD,  1, 0, 0, 5, 2, 6,  C_BUB,  0,  0,  1,   0, 0, 0,    0,  0);
        step("post_add",   K_X,    0, 0, 0, 0, 0, 0,  C_ADD,  1,  1,  0,   6, 5, 0,    0,  0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
